// File: rtl/ub_pkg.sv
// Shared types and constants for the unified-buffer access controller.
package ub_pkg;

   localparam int unsigned UB_DATA_W = 32;
   localparam int unsigned UB_ADDR_W = 13;
   localparam int unsigned UB_DEPTH  = 64;
   localparam int unsigned UB_BURST  = 4;

   typedef enum logic [2:0] {
      IDLE,
      WR_BURST,
      RD_ISSUE,
      RD_DRAIN,
      RESP
   } ub_ctrl_state_t;

   typedef enum logic {
      GNT_WR,
      GNT_RD
   } ub_gnt_t;

endpackage

// File: rtl/ub_rr_arbiter.sv
// Two-requester round-robin arbiter; the pointer flips away from the side
// reported on the update strobe.
module ub_rr_arbiter
   import ub_pkg::*;
(
   input  logic clk,
   input  logic reset_n,
   input  logic req_wr,
   input  logic req_rd,
   input  logic upd,
   input  logic upd_rd,
   output logic gnt_valid,
   output logic gnt_rd
);

   // prio_q names the side that wins when both request.
   ub_gnt_t prio_q, prio_d;

   always_comb begin
      prio_d = prio_q;
      if (upd) begin
         prio_d = upd_rd ? GNT_WR : GNT_RD;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prio_q <= GNT_WR;
      end else begin
         prio_q <= prio_d;
      end
   end

   assign gnt_valid = req_wr | req_rd;
   assign gnt_rd    = req_rd & (~req_wr | (prio_q == GNT_RD));

endmodule

// File: rtl/ub_access_controller.sv
// Serialises 4-word store/load bursts onto the single-port unified buffer,
// with round-robin arbitration and a bounds check taken at grant.
module ub_access_controller
   import ub_pkg::*;
#(
   parameter int unsigned DATA_W = UB_DATA_W,
   parameter int unsigned ADDR_W = UB_ADDR_W,
   parameter int unsigned DEPTH  = UB_DEPTH
)
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data0,
   input  logic [DATA_W-1:0] wr_data1,
   input  logic [DATA_W-1:0] wr_data2,
   input  logic [DATA_W-1:0] wr_data3,
   output logic              wr_ack,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data0,
   output logic [DATA_W-1:0] rd_data1,
   output logic [DATA_W-1:0] rd_data2,
   output logic [DATA_W-1:0] rd_data3,
   output logic              rd_valid,
   output logic              ub_we,
   output logic [ADDR_W-1:0] ub_waddr,
   output logic [DATA_W-1:0] ub_wdata,
   output logic              ub_re,
   output logic [ADDR_W-1:0] ub_raddr,
   input  logic [DATA_W-1:0] ub_rdata,
   output logic              err_oob,
   output logic              busy
);

   ub_ctrl_state_t             state_q, state_d;
   ub_gnt_t                    side_q, side_d;
   logic [ADDR_W-1:0]          base_q, base_d;
   logic [1:0]                 beat_q, beat_d;
   logic                       oob_q, oob_d;
   logic [3:0][DATA_W-1:0]     words_q, words_d;
   logic [3:0][DATA_W-1:0]     rdbuf_q, rdbuf_d;

   logic                       gnt_valid, gnt_rd;
   logic [ADDR_W-1:0]          req_base;
   logic [ADDR_W:0]            req_last;
   logic                       req_oob;

   ub_rr_arbiter u_arb (
      .clk       (clk),
      .reset_n   (reset_n),
      .req_wr    (wr_req),
      .req_rd    (rd_req),
      .upd       (state_q == RESP),
      .upd_rd    (side_q == GNT_RD),
      .gnt_valid (gnt_valid),
      .gnt_rd    (gnt_rd)
   );

   // One extra bit so base + 3 cannot wrap past the top of the address space.
   always_comb begin
      req_base = gnt_rd ? rd_addr : wr_addr;
      req_last = {1'b0, req_base} + (ADDR_W+1)'(UB_BURST - 1);
      req_oob  = req_last > (ADDR_W+1)'(DEPTH - 1);
   end

   always_comb begin
      state_d = state_q;
      side_d  = side_q;
      base_d  = base_q;
      beat_d  = beat_q;
      oob_d   = oob_q;
      words_d = words_q;
      rdbuf_d = rdbuf_q;
      unique case (state_q)
         IDLE: begin
            if (gnt_valid) begin
               side_d  = gnt_rd ? GNT_RD : GNT_WR;
               base_d  = req_base;
               beat_d  = '0;
               oob_d   = req_oob;
               words_d = {wr_data3, wr_data2, wr_data1, wr_data0};
               if (req_oob)     state_d = RESP;
               else if (gnt_rd) state_d = RD_ISSUE;
               else             state_d = WR_BURST;
            end
         end
         WR_BURST: begin
            beat_d = beat_q + 2'd1;
            if (beat_q == 2'd3) state_d = RESP;
         end
         RD_ISSUE: begin
            // Read data trails the strobe by one cycle, so beat k lands word k-1.
            if (beat_q != 2'd0) rdbuf_d[beat_q - 2'd1] = ub_rdata;
            beat_d = beat_q + 2'd1;
            if (beat_q == 2'd3) state_d = RD_DRAIN;
         end
         RD_DRAIN: begin
            rdbuf_d[3] = ub_rdata;
            state_d    = RESP;
         end
         RESP: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         side_q  <= GNT_WR;
         base_q  <= '0;
         beat_q  <= '0;
         oob_q   <= 1'b0;
         words_q <= '0;
         rdbuf_q <= '0;
      end else begin
         state_q <= state_d;
         side_q  <= side_d;
         base_q  <= base_d;
         beat_q  <= beat_d;
         oob_q   <= oob_d;
         words_q <= words_d;
         rdbuf_q <= rdbuf_d;
      end
   end

   always_comb begin
      ub_we    = (state_q == WR_BURST);
      ub_re    = (state_q == RD_ISSUE);
      ub_waddr = ub_we ? base_q + ADDR_W'(beat_q) : '0;
      ub_wdata = ub_we ? words_q[beat_q] : '0;
      ub_raddr = ub_re ? base_q + ADDR_W'(beat_q) : '0;
      wr_ack   = (state_q == RESP) && (side_q == GNT_WR);
      rd_valid = (state_q == RESP) && (side_q == GNT_RD);
      err_oob  = (state_q == RESP) && oob_q;
      busy     = (state_q != IDLE);
      rd_data0 = rdbuf_q[0];
      rd_data1 = rdbuf_q[1];
      rd_data2 = rdbuf_q[2];
      rd_data3 = rdbuf_q[3];
   end

endmodule
